pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, meaning PC and instruction width in bits.
REQ-002 Parameter SKID, default 1, meaning 1 = registered ready with 2-entry skid buffer, 0 = single register with combinational ready.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, meaning bubble instruction presented when the stage is empty.
REQ-004 Parameter CNT_W, default 16, meaning stall-counter width in bits.
REQ-005 clk_in  input  1  single clock; all state updates on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 flush_in  input  1  discard all held and incoming entries.
REQ-008 valid_in  input  1  upstream entry present.
REQ-009 ready_out  output  1  stage accepts an entry this cycle.
REQ-010 pc_in, instr_in  input  WIDTH each  upstream payload.
REQ-011 valid_out  output  1  downstream entry present.
REQ-012 ready_in  input  1  downstream accepts an entry this cycle.
REQ-013 pc_out, instr_out  output  WIDTH each  downstream payload.
REQ-014 stall_cnt_out  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-015 Transfer in occurs when valid_in & ready_out; transfer out occurs when valid_out & ready_in.
REQ-016 Latency: an entry accepted at edge N appears at pc_out/instr_out/valid_out after edge N (1 cycle), in order, never duplicated or dropped.
REQ-017 SKID=1 state machine: EMPTY, BUSY (main full), FULL (main and skid full).
REQ-018 EMPTY: valid_in -> BUSY, load main.
REQ-019 BUSY: valid_in & ready_in -> BUSY, load main; valid_in & !ready_in -> FULL, load skid; !valid_in & ready_in -> EMPTY; otherwise hold.
REQ-020 FULL: ready_in -> BUSY, skid moves to main; otherwise hold.
REQ-021 SKID=1: ready_out is a register output, 1 in EMPTY/BUSY, 0 in FULL; no combinational path from ready_in to ready_out.
REQ-022 SKID=0: states EMPTY/BUSY only; ready_out = ready_in | !valid_out (combinational); the FULL state and skid storage are absent.
REQ-023 valid_out = 1 exactly when state is BUSY or FULL; outputs always come from main.
REQ-024 When valid_out = 0, pc_out = 0 and instr_out = NOP_INSTR.
REQ-025 flush_in has highest priority: next state EMPTY, main and skid cleared to bubble, the concurrent upstream entry is dropped even when ready_out = 1.
REQ-026 Flush and accept in the same cycle: the upstream sees the transfer complete, and the entry is discarded.
REQ-027 stall_cnt_out increments by 1 each cycle with valid_out & !ready_in, saturates at 2^CNT_W-1, and is not cleared by flush.
REQ-028 ready_in toggling while valid_out = 0 has no effect on state.

Reset
REQ-029 rst_in low asynchronously forces state EMPTY, valid_out 0, pc_out 0, instr_out NOP_INSTR, stall_cnt_out 0, and ready_out 1 (SKID=1).
REQ-030 Reset mid-operation discards all held entries; the first accept is possible at the first rising edge after rst_in deasserts.

Structure
REQ-031 Package pipe_pkg holds the state enum (EMPTY, BUSY, FULL) and the default NOP_INSTR constant.
REQ-032 The saturating stall counter is one sub-module, pipe_stall_ctr, parameterised by CNT_W.
REQ-033 Skid storage is generated only when SKID=1.

Verification
REQ-034 Streaming: valid_in=1 and ready_in=1 constantly with pc 0x100, 0x104, 0x108 -> each pc appears on pc_out one cycle later; stall_cnt_out stays 0.
REQ-035 Backpressure, SKID=1: ready_in=0 while pc 0x200 and 0x204 are sent -> state FULL, ready_out=0 on the next edge, and 0x204 is not lost; when ready_in returns to 1, the outputs are 0x200 then 0x204.
REQ-036 Flush: with FULL holding 0x300/0x304, flush_in=1 and valid_in=1 with 0x308 -> the next cycle has valid_out=0, instr_out=0x00000013, and 0x308 never appears.
REQ-037 Saturation: CNT_W=4, valid_out=1 and ready_in=0 for 20 cycles -> stall_cnt_out=15.
REQ-038 Async reset: rst_in pulsed low between edges while in BUSY -> valid_out=0, pc_out=0, instr_out=0x00000013 immediately, without waiting for a clock edge.
REQ-039 SKID=0: ready_in=0 while valid_out=1 -> ready_out=0 in the same cycle; when ready_in rises, ready_out=1 in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_stage slice.
package pipe_pkg;

  // Occupancy of the stage: nothing held, main held, or main and skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Bubble instruction (addi x0,x0,0) shown downstream while the stage is empty.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating counter of back-pressured cycles; never wraps.
module pipe_stall_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count up while requested, holding at all-ones once reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// Single pipeline register stage for a PC/instruction pair with optional
// 2-entry skid buffer (registered ready) or plain register (comb ready).
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_INSTR_DEF),
  parameter int               CNT_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instr_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_pc_q, main_pc_d;
  logic [WIDTH-1:0] main_instr_q, main_instr_d;
  logic [WIDTH-1:0] skid_pc, skid_instr;
  logic             skid_ld;
  logic             vld;
  logic             acc;

  assign vld = (state_q != EMPTY);
  assign acc = valid_in & ready_out;

  // Next-state and main-register load; flush overrides everything and
  // swallows any concurrent upstream transfer.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_ld      = 1'b0;
    if (flush_in) begin
      state_d      = EMPTY;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = BUSY;
            main_pc_d    = pc_in;
            main_instr_d = instr_in;
          end
        end
        BUSY: begin
          if (acc && ready_in) begin
            main_pc_d    = pc_in;
            main_instr_d = instr_in;
          end else if (acc && SKID != 0) begin
            // Downstream stalled but we already promised ready: park in skid.
            state_d = FULL;
            skid_ld = 1'b1;
          end else if (!valid_in && ready_in) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (ready_in) begin
            state_d      = BUSY;
            main_pc_d    = skid_pc;
            main_instr_d = skid_instr;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and main payload registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_pc_q, skid_instr_q;
      logic             rdy_q;

      // Skid entry captured only on a stalled accept; cleared on flush.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          skid_pc_q    <= '0;
          skid_instr_q <= NOP_INSTR;
        end else if (flush_in) begin
          skid_pc_q    <= '0;
          skid_instr_q <= NOP_INSTR;
        end else if (skid_ld) begin
          skid_pc_q    <= pc_in;
          skid_instr_q <= instr_in;
        end
      end

      // Registered ready: low only while both entries are occupied.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rdy_q <= 1'b1;
        else         rdy_q <= (state_d != FULL);
      end

      assign skid_pc    = skid_pc_q;
      assign skid_instr = skid_instr_q;
      assign ready_out  = rdy_q;
    end else begin : g_noskid
      assign skid_pc    = '0;
      assign skid_instr = NOP_INSTR;
      assign ready_out  = ready_in | ~vld;
    end
  endgenerate

  assign valid_out = vld;
  assign pc_out    = vld ? main_pc_q    : '0;
  assign instr_out = vld ? main_instr_q : NOP_INSTR;

  pipe_stall_ctr #(.CNT_W(CNT_W)) u_stall (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .inc_i  (vld & ~ready_in),
    .cnt_o  (stall_cnt_out)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench: SKID=1/CNT_W=4 instance for streaming, backpressure,
// flush, saturation, reset; SKID=0 instance for combinational ready.
module tb_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        fl = 0, vi = 0, ri = 0, ro, vo;
  logic [31:0] pci = 0, ii = 0, pco, io;
  logic [3:0]  sc;
  // SKID=0 instance
  logic        vi0 = 0, ri0 = 0, ro0, vo0;
  logic [31:0] pc0i = 0, pco0, io0;
  logic [15:0] sc0;

  pipe_stage #(.SKID(1), .CNT_W(4)) dut (
    .clk_in(clk), .rst_in(rst_n), .flush_in(fl), .valid_in(vi), .ready_out(ro),
    .pc_in(pci), .instr_in(ii), .valid_out(vo), .ready_in(ri),
    .pc_out(pco), .instr_out(io), .stall_cnt_out(sc));

  pipe_stage #(.SKID(0)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .flush_in(1'b0), .valid_in(vi0), .ready_out(ro0),
    .pc_in(pc0i), .instr_in(pc0i ^ 32'hDEAD_0000), .valid_out(vo0), .ready_in(ri0),
    .pc_out(pco0), .instr_out(io0), .stall_cnt_out(sc0));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t sbq[$];

  // Scoreboard: sample mid-cycle the transfers the next rising edge will make.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vo && ri) begin
        chk("sb_nonempty", 64'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          ent_t e;
          e = sbq.pop_front();
          chk("sb_pc", pco, e.pc);
          chk("sb_ins", io, e.ins);
        end
      end else if (!vo) begin
        chk("bub_pc", pco, 0);
        chk("bub_ins", io, NOP);
      end
      if (fl) sbq.delete();
      else if (vi && ro) sbq.push_back('{pc: pci, ins: ii});
    end
  end

  task automatic drv(input logic v, input logic [31:0] pc, input logic r, input logic f);
    vi = v; pci = pc; ii = mk_ins(pc); ri = r; fl = f;
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_vo", vo, 0); chk("rst_pc", pco, 0); chk("rst_ins", io, NOP);
    chk("rst_sc", sc, 0); chk("rst_ro", ro, 1); chk("rst_ro0", ro0, 1);
    @(negedge clk) rst_n = 1'b1;

    // streaming
    drv(1, 32'h100, 1, 0); chk("str_pc0", pco, 32'h100);
    drv(1, 32'h104, 1, 0); chk("str_pc1", pco, 32'h104);
    drv(1, 32'h108, 1, 0); chk("str_pc2", pco, 32'h108);
    drv(0, 0, 1, 0);       chk("str_end_vo", vo, 0);
    chk("str_sc", sc, 0);

    // backpressure into skid
    drv(1, 32'h200, 0, 0);
    drv(1, 32'h204, 0, 0);
    chk("bp_ro", ro, 0); chk("bp_vo", vo, 1); chk("bp_pc", pco, 32'h200);
    drv(0, 0, 1, 0); chk("bp_pc2", pco, 32'h204); chk("bp_ro2", ro, 1);
    drv(0, 0, 1, 0); chk("bp_vo_end", vo, 0); chk("bp_sc", sc, 1);

    // flush while FULL, then flush concurrent with accept
    drv(1, 32'h300, 0, 0);
    drv(1, 32'h304, 0, 0); chk("fl_full_ro", ro, 0);
    drv(1, 32'h308, 0, 1);
    chk("fl_vo", vo, 0); chk("fl_ins", io, NOP); chk("fl_pc", pco, 0);
    chk("fl_ro", ro, 1); chk("fl_sc", sc, 3);
    drv(1, 32'h310, 1, 1); chk("fl_acc_vo", vo, 0);
    drv(1, 32'h314, 1, 0); chk("fl_after_pc", pco, 32'h314);
    drv(0, 0, 1, 0);

    // ready_in toggling while empty
    drv(0, 0, 0, 0); drv(0, 0, 1, 0); drv(0, 0, 0, 0);
    chk("tog_vo", vo, 0); chk("tog_ro", ro, 1); chk("tog_sc", sc, 3);

    // saturation
    drv(1, 32'h400, 0, 0);
    for (int i = 0; i < 20; i++) drv(0, 0, 0, 0);
    chk("sat_sc", sc, 15); chk("sat_pc", pco, 32'h400);

    // async reset between edges while BUSY
    #3 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("ar_vo", vo, 0); chk("ar_pc", pco, 0); chk("ar_ins", io, NOP);
    chk("ar_sc", sc, 0); chk("ar_ro", ro, 1);
    @(negedge clk) rst_n = 1'b1;
    drv(1, 32'h500, 1, 0); chk("ar_first_pc", pco, 32'h500);
    drv(0, 0, 1, 0);

    // random traffic through the scoreboard
    for (int i = 0; i < 300; i++)
      drv(1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4),
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    for (int i = 0; i < 4; i++) drv(0, 0, 1, 0);
    chk("sb_drain", sbq.size(), 0);

    // SKID=0: combinational ready
    vi0 = 1; pc0i = 32'h600; ri0 = 1;
    @(posedge clk); #1;
    chk("s0_vo", vo0, 1); chk("s0_pc", pco0, 32'h600);
    vi0 = 0; ri0 = 0; #1;
    chk("s0_ro_lo", ro0, 0);
    ri0 = 1; #1;
    chk("s0_ro_hi", ro0, 1);
    vi0 = 1; pc0i = 32'h604; ri0 = 0;
    @(posedge clk); #1;
    chk("s0_hold_pc", pco0, 32'h600); chk("s0_sc", sc0, 1);
    ri0 = 1;
    @(posedge clk); #1;
    chk("s0_pc2", pco0, 32'h604); chk("s0_ins2", io0, mk_ins(32'h604));
    vi0 = 0;
    @(posedge clk); #1;
    chk("s0_vo_end", vo0, 0);
    ri0 = 0; #1;
    chk("s0_ro_empty", ro0, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
